// File: rtl/axi_bridge_pkg.sv
// Shared definitions for the AXI4-Lite to on-chip memory bridge.
// Holds the bridge FSM state type, the AXI response codes, the default memory
// geometry and a helper that tells whether a byte address falls inside the
// memory.
package axi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    WR_EXEC,
    WR_RESP,
    RD_EXEC,
    RD_WAIT,
    RD_RESP
  } bridge_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DEF_MEM_WORDS = 128;
  localparam int MEM_AW        = $clog2(DEF_MEM_WORDS);

  // True when a byte address lands inside a memory of 'words' 32-bit words.
  function automatic logic addr_in_range(input logic [31:0] byte_addr, input int words);
    return byte_addr < (32'(words) * 32'd4);
  endfunction

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-requester round-robin arbiter (write vs read).
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   req_wr, req_rd  : pending write / read requests
//   take            : the grant is being consumed this cycle, update history
//   gnt_wr, gnt_rd  : combinational one-hot grant
// After reset the history says "read went last", so a tie goes to the write.
module axi_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req_wr,
  input  logic req_rd,
  input  logic take,
  output logic gnt_wr,
  output logic gnt_rd
);

  logic last_rd;

  // On a tie the requester that did not win last time gets the grant.
  assign gnt_wr = req_wr && (!req_rd || last_rd);
  assign gnt_rd = req_rd && (!req_wr || !last_rd);

  // Remember who won, but only when the winner is actually taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_rd <= 1'b1;
    end else if (take && (gnt_wr || gnt_rd)) begin
      last_rd <= gnt_rd;
    end
  end

endmodule

// File: rtl/axi4lite_onchip_mem_bridge.sv
// AXI4-Lite slave to Avalon-MM master bridge in front of the on-chip memory.
// One transaction at a time; reads and writes are arbitrated round-robin.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*                  : AXI4-Lite write address/data/response
//   s_ar*/s_r*                       : AXI4-Lite read address/data
//   mem_address/chipselect/write     : registered single-cycle memory strobes
//   mem_writedata/byteenable         : write payload, byte enables
//   mem_readdata                     : memory read data (RD_LATENCY cycles)
//   mem_clken, mem_reset_req         : constant enable, reset pass-through
// Every output is registered, so each state drives its strobes one cycle
// after it is entered; this gives bvalid two cycles after the last write
// handshake and rvalid RD_LATENCY+2 cycles after the read handshake.
module axi4lite_onchip_mem_bridge
  import axi_bridge_pkg::*;
#(
  parameter int AXI_ADDR_W = 12,
  parameter int MEM_WORDS  = DEF_MEM_WORDS,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [AXI_ADDR_W-1:0]         s_awaddr,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  input  logic [31:0]                   s_wdata,
  input  logic [3:0]                    s_wstrb,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  output logic [1:0]                    s_bresp,
  output logic                          s_bvalid,
  input  logic                          s_bready,
  input  logic [AXI_ADDR_W-1:0]         s_araddr,
  input  logic                          s_arvalid,
  output logic                          s_arready,
  output logic [31:0]                   s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rvalid,
  input  logic                          s_rready,
  output logic [$clog2(MEM_WORDS)-1:0]  mem_address,
  output logic                          mem_clken,
  output logic                          mem_chipselect,
  output logic                          mem_write,
  input  logic [31:0]                   mem_readdata,
  output logic [31:0]                   mem_writedata,
  output logic [3:0]                    mem_byteenable,
  output logic                          mem_reset_req
);

  localparam int WORD_AW = $clog2(MEM_WORDS);

  bridge_state_t      state;
  logic               aw_done, w_done;
  logic [WORD_AW-1:0] wr_idx, rd_idx;
  logic               wr_ok, rd_ok;
  logic [31:0]        wr_data;
  logic [3:0]         wr_strb;
  logic [2:0]         rd_cnt;
  logic               gnt_wr, gnt_rd, arb_take;
  logic               aw_hs, w_hs;

  assign mem_clken     = 1'b1;
  assign mem_reset_req = reset;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;

  // A pending arready means a read grant is already out, so no re-arbitration.
  assign arb_take = (state == IDLE) && !s_arready;

  axi_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req_wr (s_awvalid || s_wvalid),
    .req_rd (s_arvalid),
    .take   (arb_take),
    .gnt_wr (gnt_wr),
    .gnt_rd (gnt_rd)
  );

  // Bridge FSM. Memory strobes default low every cycle and are raised only
  // from WR_EXEC / RD_EXEC, so they are single-cycle pulses. Out-of-range
  // addresses walk the same states but never touch the memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      s_awready      <= 1'b0;
      s_wready       <= 1'b0;
      s_arready      <= 1'b0;
      s_bvalid       <= 1'b0;
      s_bresp        <= RESP_OKAY;
      s_rvalid       <= 1'b0;
      s_rresp        <= RESP_OKAY;
      s_rdata        <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_writedata  <= '0;
      mem_byteenable <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      wr_idx         <= '0;
      rd_idx         <= '0;
      wr_ok          <= 1'b0;
      rd_ok          <= 1'b0;
      wr_data        <= '0;
      wr_strb        <= '0;
      rd_cnt         <= '0;
    end else begin
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      case (state)
        IDLE: begin
          if (s_arready) begin
            s_arready <= 1'b0;
            if (s_arvalid) begin
              rd_idx <= s_araddr[WORD_AW+1:2];
              rd_ok  <= addr_in_range(32'(s_araddr), MEM_WORDS);
              state  <= RD_EXEC;
            end
          end else if (gnt_wr) begin
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            state     <= WR_COLLECT;
          end else if (gnt_rd) begin
            s_arready <= 1'b1;
          end
        end
        WR_COLLECT: begin
          if (aw_hs) begin
            s_awready <= 1'b0;
            aw_done   <= 1'b1;
            wr_idx    <= s_awaddr[WORD_AW+1:2];
            wr_ok     <= addr_in_range(32'(s_awaddr), MEM_WORDS);
          end
          if (w_hs) begin
            s_wready <= 1'b0;
            w_done   <= 1'b1;
            wr_data  <= s_wdata;
            wr_strb  <= s_wstrb;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state <= WR_EXEC;
          end
        end
        WR_EXEC: begin
          if (wr_ok) begin
            mem_chipselect <= 1'b1;
            mem_write      <= 1'b1;
            mem_address    <= wr_idx;
            mem_writedata  <= wr_data;
            mem_byteenable <= wr_strb;
          end
          s_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
          state   <= WR_RESP;
        end
        WR_RESP: begin
          if (!s_bvalid) begin
            s_bvalid <= 1'b1;
          end else if (s_bready) begin
            s_bvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        RD_EXEC: begin
          if (rd_ok) begin
            mem_chipselect <= 1'b1;
            mem_address    <= rd_idx;
            mem_byteenable <= 4'hF;
          end
          rd_cnt <= '0;
          state  <= RD_WAIT;
        end
        // The memory samples the strobe on the first RD_WAIT edge; its data
        // is valid RD_LATENCY edges after that.
        RD_WAIT: begin
          if (rd_cnt == 3'(RD_LATENCY)) begin
            s_rdata  <= rd_ok ? mem_readdata : 32'h0;
            s_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            s_rvalid <= 1'b1;
            state    <= RD_RESP;
          end else begin
            rd_cnt <= rd_cnt + 3'd1;
          end
        end
        RD_RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_onchip_mem_bridge.sv
// Self-checking bench for axi4lite_onchip_mem_bridge: a latency-1 memory
// model with an access log, a table of directed single transactions, and
// hand-written sequences for the multi-cycle corner cases.
module tb_axi4lite_onchip_mem_bridge;
  import axi_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] s_awaddr, s_araddr;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [6:0]  mem_address;
  logic        mem_clken, mem_chipselect, mem_write, mem_reset_req;
  logic [31:0] mem_readdata, mem_writedata;
  logic [3:0]  mem_byteenable;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       wr;
    logic [6:0] addr;
    logic [3:0] be;
    logic [31:0] wd;
  } acc_t;
  acc_t acc_log[$];

  logic [31:0] mem_model [0:DEF_MEM_WORDS-1];

  typedef struct {
    bit          is_wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    bit          access;
    logic [6:0]  widx;
    logic [3:0]  be;
  } vec_t;
  vec_t vecs[13];

  logic [1:0]  g_resp, r1_resp, r2_resp, w1_resp, w2_resp;
  logic [31:0] g_rdata, r1_data, r2_data;
  int          g_lat, r1_lat, r2_lat, w1_lat, w2_lat;

  axi4lite_onchip_mem_bridge dut (
    .clk            (clk),
    .reset          (reset),
    .s_awaddr       (s_awaddr),
    .s_awvalid      (s_awvalid),
    .s_awready      (s_awready),
    .s_wdata        (s_wdata),
    .s_wstrb        (s_wstrb),
    .s_wvalid       (s_wvalid),
    .s_wready       (s_wready),
    .s_bresp        (s_bresp),
    .s_bvalid       (s_bvalid),
    .s_bready       (s_bready),
    .s_araddr       (s_araddr),
    .s_arvalid      (s_arvalid),
    .s_arready      (s_arready),
    .s_rdata        (s_rdata),
    .s_rresp        (s_rresp),
    .s_rvalid       (s_rvalid),
    .s_rready       (s_rready),
    .mem_address    (mem_address),
    .mem_clken      (mem_clken),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_readdata   (mem_readdata),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_reset_req  (mem_reset_req)
  );

  always #5 clk = ~clk;

  // Edge counter used to measure response latency in cycles.
  always @(posedge clk) cyc <= cyc + 1;

  // On-chip memory with read latency 1; every selected cycle is logged.
  always @(posedge clk) begin
    if (mem_chipselect) begin
      acc_log.push_back('{mem_write, mem_address, mem_byteenable, mem_writedata});
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) mem_model[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end else begin
        mem_readdata <= mem_model[mem_address];
      end
    end
  end

  // Global guard so a stuck DUT can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got timeout want response", name);
  endtask

  task automatic waitBresp(input int hs, output logic [1:0] resp, output int lat);
    int t = 0;
    while (!s_bvalid && t < 40) begin
      tick();
      t++;
    end
    if (!s_bvalid) timeoutFail("b_valid");
    lat  = cyc - hs;
    resp = s_bresp;
    if (s_bvalid && s_bready) tick();
  endtask

  task automatic sendWrite(input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output int hs);
    int t = 0;
    logic aw_h, w_h;
    hs = 0;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    while ((s_awvalid || s_wvalid) && t < 40) begin
      aw_h = s_awvalid && s_awready;
      w_h  = s_wvalid && s_wready;
      tick();
      t++;
      if (aw_h) begin s_awvalid = 1'b0; hs = cyc; end
      if (w_h)  begin s_wvalid  = 1'b0; hs = cyc; end
    end
    if (s_awvalid || s_wvalid) begin
      timeoutFail("aw_w_handshake");
      s_awvalid = 1'b0; s_wvalid = 1'b0;
    end
  endtask

  task automatic doWrite(input logic [11:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output logic [1:0] resp, output int lat);
    int hs;
    sendWrite(addr, data, strb, hs);
    waitBresp(hs, resp, lat);
  endtask

  task automatic doRead(input logic [11:0] addr, output logic [1:0] resp,
                        output logic [31:0] data, output int lat);
    int t = 0;
    int hs = 0;
    logic h;
    s_araddr = addr; s_arvalid = 1'b1;
    while (s_arvalid && t < 40) begin
      h = s_arready;
      tick();
      t++;
      if (h) begin s_arvalid = 1'b0; hs = cyc; end
    end
    if (s_arvalid) begin timeoutFail("ar_handshake"); s_arvalid = 1'b0; end
    t = 0;
    while (!s_rvalid && t < 40) begin
      tick();
      t++;
    end
    if (!s_rvalid) timeoutFail("r_valid");
    lat  = cyc - hs;
    resp = s_rresp;
    data = s_rdata;
    if (s_rvalid && s_rready) tick();
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.is_wr) doWrite(v.addr, v.data, v.strb, g_resp, g_lat);
    else         doRead(v.addr, g_resp, g_rdata, g_lat);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int n0;
    acc_t e;
    bit ar_seen, b_drop, r_seen;

    for (int i = 0; i < DEF_MEM_WORDS; i++) mem_model[i] = 32'h0;
    mem_readdata = 32'h0;
    reset = 1'b1;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_araddr = '0; s_arvalid = 0; s_bready = 1; s_rready = 1;

    vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        1'b1, 7'd4,   4'hF};
    vecs[1]  = '{1'b0, 12'h010, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 1'b1, 7'd4,   4'hF};
    vecs[2]  = '{1'b1, 12'h014, 32'h12345678, 4'hF, 2'b00, 32'h0,        1'b1, 7'd5,   4'hF};
    vecs[3]  = '{1'b1, 12'h014, 32'hAABBCCDD, 4'h3, 2'b00, 32'h0,        1'b1, 7'd5,   4'h3};
    vecs[4]  = '{1'b0, 12'h014, 32'h0,        4'h0, 2'b00, 32'h1234CCDD, 1'b1, 7'd5,   4'hF};
    vecs[5]  = '{1'b1, 12'h1FF, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0,        1'b1, 7'd127, 4'hF};
    vecs[6]  = '{1'b0, 12'h1FC, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D, 1'b1, 7'd127, 4'hF};
    vecs[7]  = '{1'b0, 12'h200, 32'h0,        4'h0, 2'b10, 32'h0,        1'b0, 7'd0,   4'h0};
    vecs[8]  = '{1'b1, 12'h3FC, 32'h55555555, 4'hF, 2'b10, 32'h0,        1'b0, 7'd0,   4'h0};
    vecs[9]  = '{1'b1, 12'h010, 32'h00000000, 4'h0, 2'b00, 32'h0,        1'b1, 7'd4,   4'h0};
    vecs[10] = '{1'b0, 12'h010, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 1'b1, 7'd4,   4'hF};
    vecs[11] = '{1'b0, 12'hFFF, 32'h0,        4'h0, 2'b10, 32'h0,        1'b0, 7'd0,   4'h0};
    vecs[12] = '{1'b0, 12'h013, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 1'b1, 7'd4,   4'hF};

    // Reset values while reset is still high.
    tick(); tick(); tick();
    checkOutput("rst_awready", s_awready, 0);
    checkOutput("rst_wready", s_wready, 0);
    checkOutput("rst_arready", s_arready, 0);
    checkOutput("rst_bvalid", s_bvalid, 0);
    checkOutput("rst_rvalid", s_rvalid, 0);
    checkOutput("rst_bresp", s_bresp, 0);
    checkOutput("rst_rresp", s_rresp, 0);
    checkOutput("rst_rdata", s_rdata, 0);
    checkOutput("rst_cs", mem_chipselect, 0);
    checkOutput("rst_write", mem_write, 0);
    checkOutput("rst_addr", mem_address, 0);
    checkOutput("rst_wdata", mem_writedata, 0);
    checkOutput("rst_be", mem_byteenable, 0);
    checkOutput("rst_reset_req", mem_reset_req, 1);
    checkOutput("rst_clken", mem_clken, 1);
    reset = 1'b0;
    tick();
    checkOutput("run_reset_req", mem_reset_req, 0);

    // Table of single transactions.
    for (int i = 0; i < 13; i++) begin
      n0 = acc_log.size();
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_resp", i), g_resp, vecs[i].resp);
      checkOutput($sformatf("v%0d_lat", i), g_lat, vecs[i].is_wr ? 2 : 3);
      if (!vecs[i].is_wr) checkOutput($sformatf("v%0d_rdata", i), g_rdata, vecs[i].rdata);
      checkOutput($sformatf("v%0d_accesses", i), acc_log.size() - n0, vecs[i].access ? 1 : 0);
      if (vecs[i].access && acc_log.size() > n0) begin
        e = acc_log[acc_log.size()-1];
        checkOutput($sformatf("v%0d_mem_write", i), e.wr, vecs[i].is_wr);
        checkOutput($sformatf("v%0d_mem_addr", i), e.addr, vecs[i].widx);
        checkOutput($sformatf("v%0d_mem_be", i), e.be, vecs[i].be);
        if (vecs[i].is_wr) checkOutput($sformatf("v%0d_mem_wdata", i), e.wd, vecs[i].data);
      end
    end

    // W leads AW by three cycles: nothing reaches memory until AW arrives.
    begin
      int t = 0;
      int hs = 0;
      logic h;
      s_awaddr = 12'h020; s_wdata = 32'h11223344; s_wstrb = 4'b0101; s_wvalid = 1'b1;
      while (s_wvalid && t < 40) begin
        h = s_wready;
        tick();
        t++;
        if (h) s_wvalid = 1'b0;
      end
      if (s_wvalid) begin timeoutFail("wfirst_w_hs"); s_wvalid = 1'b0; end
      n0 = acc_log.size();
      tick(); tick(); tick();
      checkOutput("wfirst_no_access", acc_log.size() - n0, 0);
      checkOutput("wfirst_awready_held", s_awready, 1);
      checkOutput("wfirst_wready_low", s_wready, 0);
      s_awvalid = 1'b1;
      t = 0;
      while (s_awvalid && t < 40) begin
        h = s_awready;
        tick();
        t++;
        if (h) begin s_awvalid = 1'b0; hs = cyc; end
      end
      if (s_awvalid) begin timeoutFail("wfirst_aw_hs"); s_awvalid = 1'b0; end
      waitBresp(hs, g_resp, g_lat);
      checkOutput("wfirst_lat", g_lat, 2);
      checkOutput("wfirst_resp", g_resp, 2'b00);
      checkOutput("wfirst_accesses", acc_log.size() - n0, 1);
      if (acc_log.size() > n0) begin
        e = acc_log[acc_log.size()-1];
        checkOutput("wfirst_be", e.be, 4'b0101);
        checkOutput("wfirst_addr", e.addr, 7'd8);
      end
      doRead(12'h020, g_resp, g_rdata, g_lat);
      checkOutput("wfirst_readback", g_rdata, 32'h00220044);
    end

    // Simultaneous write and read from reset, twice: order W,R,W,R.
    doReset();
    n0 = acc_log.size();
    fork
      doWrite(12'h040, 32'hA5A5A5A5, 4'hF, w1_resp, w1_lat);
      doRead(12'h010, r1_resp, r1_data, r1_lat);
    join
    fork
      doWrite(12'h044, 32'h5A5A5A5A, 4'hF, w2_resp, w2_lat);
      doRead(12'h040, r2_resp, r2_data, r2_lat);
    join
    checkOutput("arb_accesses", acc_log.size() - n0, 4);
    if (acc_log.size() >= n0 + 4) begin
      checkOutput("arb_first_wr", acc_log[n0].wr, 1);
      checkOutput("arb_first_addr", acc_log[n0].addr, 7'd16);
      checkOutput("arb_second_wr", acc_log[n0+1].wr, 0);
      checkOutput("arb_third_wr", acc_log[n0+2].wr, 1);
      checkOutput("arb_fourth_wr", acc_log[n0+3].wr, 0);
    end
    checkOutput("arb_r1_data", r1_data, 32'hDEADBEEF);
    checkOutput("arb_r2_data", r2_data, 32'hA5A5A5A5);
    checkOutput("arb_w2_resp", w2_resp, 2'b00);

    // Write response held off: bvalid stays up and no read is accepted.
    begin
      int hs;
      s_bready = 1'b0;
      sendWrite(12'h050, 32'h0F0F0F0F, 4'hF, hs);
      s_araddr = 12'h050; s_arvalid = 1'b1;
      ar_seen = 0; b_drop = 0;
      tick(); tick();
      for (int k = 0; k < 6; k++) begin
        tick();
        if (s_arready) ar_seen = 1;
        if (!s_bvalid) b_drop = 1;
      end
      checkOutput("bp_arready_blocked", ar_seen, 0);
      checkOutput("bp_bvalid_held", b_drop, 0);
      checkOutput("bp_bresp", s_bresp, 2'b00);
      s_bready = 1'b1;
      tick();
      doRead(12'h050, g_resp, g_rdata, g_lat);
      checkOutput("bp_read_data", g_rdata, 32'h0F0F0F0F);
    end

    // Reset while waiting on read data with rready low.
    begin
      int t = 0;
      logic h;
      s_rready = 1'b0;
      s_araddr = 12'h010; s_arvalid = 1'b1;
      while (s_arvalid && t < 40) begin
        h = s_arready;
        tick();
        t++;
        if (h) s_arvalid = 1'b0;
      end
      if (s_arvalid) begin timeoutFail("rstmid_ar_hs"); s_arvalid = 1'b0; end
      tick();
      checkOutput("rstmid_in_rd_wait", dut.state, RD_WAIT);
      reset = 1'b1;
      tick();
      checkOutput("rstmid_rvalid", s_rvalid, 0);
      checkOutput("rstmid_arready", s_arready, 0);
      checkOutput("rstmid_cs", mem_chipselect, 0);
      checkOutput("rstmid_state", dut.state, IDLE);
      checkOutput("rstmid_reset_req", mem_reset_req, 1);
      reset = 1'b0;
      n0 = acc_log.size();
      r_seen = 0;
      for (int k = 0; k < 6; k++) begin
        tick();
        if (s_rvalid) r_seen = 1;
      end
      checkOutput("rstmid_no_response", r_seen, 0);
      checkOutput("rstmid_no_access", acc_log.size() - n0, 0);
      s_rready = 1'b1;
      doRead(12'h014, g_resp, g_rdata, g_lat);
      checkOutput("rstmid_after_read", g_rdata, 32'h1234CCDD);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4lite_onchip_mem_bridge.md
Name: axi4lite_onchip_mem_bridge

Overview:
AXI4-Lite slave to Avalon-MM master bridge feeding the on-chip memory (128 x 32-bit, read latency 1) from the AXI simulation master. Sits directly upstream of the memory: converts AW/W/B and AR/R channel handshakes into single-cycle chipselect/write strobes and captures the memory's readdata into the R channel. One transaction in flight at a time, reads and writes arbitrated round-robin.

Parameters:
AXI_ADDR_W, 12, AXI byte-address width
MEM_WORDS, 128, memory depth in 32-bit words (word index width = log2(MEM_WORDS) = 7)
RD_LATENCY, 1, memory read latency in clk cycles (range 1-4)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
s_awaddr  in  AXI_ADDR_W  write byte address
s_awvalid  in  1  AW valid
s_awready  out  1  AW ready
s_wdata  in  32  write data
s_wstrb  in  4  write byte strobes
s_wvalid  in  1  W valid
s_wready  out  1  W ready
s_bresp  out  2  write response (00 OKAY, 10 SLVERR)
s_bvalid  out  1  B valid
s_bready  in  1  B ready
s_araddr  in  AXI_ADDR_W  read byte address
s_arvalid  in  1  AR valid
s_arready  out  1  AR ready
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rvalid  out  1  R valid
s_rready  in  1  R ready
mem_address  out  7  memory word address
mem_clken  out  1  memory clock enable
mem_chipselect  out  1  memory select
mem_write  out  1  memory write strobe
mem_readdata  in  32  memory read data
mem_writedata  out  32  memory write data
mem_byteenable  out  4  memory byte enables
mem_reset_req  out  1  memory reset request

Behaviour:
- One clock (clk); reset synchronous active-high, sampled on rising clk edge.
- Reset values: all s_*ready/s_*valid 0, s_bresp/s_rresp 00, s_rdata 0, mem_chipselect 0, mem_write 0, mem_address 0, mem_writedata 0, mem_byteenable 0; state IDLE; round-robin pointer favours write. Any in-flight transaction discarded, no response issued.
- mem_clken = 1 constant; mem_reset_req = reset (combinational pass-through).
- States: IDLE, WR_COLLECT, WR_EXEC, WR_RESP, RD_EXEC, RD_WAIT, RD_RESP.
- IDLE arbitration: write request = s_awvalid|s_wvalid; read request = s_arvalid. Both pending -> grant the one not granted last; else grant whichever is pending. Write grant -> WR_COLLECT. Read grant -> s_arready=1 for one cycle, capture araddr on handshake -> RD_EXEC.
- WR_COLLECT: s_awready=1 until AW captured, s_wready=1 until W captured, independently, any order or same cycle; both captured -> WR_EXEC. Readies are registered outputs, deasserted the cycle after their handshake.
- Address check: word index = addr[8:2]; addr >= MEM_WORDS*4 -> SLVERR, no memory access (chipselect stays 0), s_rdata = 0. Bits [1:0] ignored.
- WR_EXEC (1 cycle): mem_chipselect=1, mem_write=1, mem_address, mem_writedata=wdata, mem_byteenable=wstrb -> WR_RESP. wstrb=0000 still issues a write with byteenable 0000 and returns OKAY.
- WR_RESP: s_bvalid=1 held with s_bresp stable until s_bready; then IDLE. bvalid rises 2 cycles after the later of AW/W handshake.
- RD_EXEC (1 cycle): mem_chipselect=1, mem_write=0, mem_byteenable=1111 -> RD_WAIT.
- RD_WAIT: count RD_LATENCY cycles; on the last one capture mem_readdata into s_rdata -> RD_RESP.
- RD_RESP: s_rvalid=1, s_rdata/s_rresp stable until s_rready; then IDLE. For RD_LATENCY=1, rvalid rises 3 cycles after AR handshake.
- Backpressure: bready/rready held low indefinitely blocks all new transactions; no requests accepted outside IDLE/WR_COLLECT.
- Memory strobes never asserted outside WR_EXEC/RD_EXEC.

Decomposition:
- Shared package axi_bridge_pkg: state enum, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, MEM_AW localparam derived from MEM_WORDS.
- One natural sub-module: axi_rr_arb2 (two-requester round-robin arbiter with last-grant flop). Remainder in a single FSM.

Test Plan:
- Write addr 0x010, data 0xDEADBEEF, strb 1111 -> one cycle chipselect=1, write=1, address=4, byteenable=1111; bvalid 2 cycles later, bresp=00.
- Read addr 0x010 after the above, memory model latency 1 -> address=4, chipselect pulse; rvalid 3 cycles after AR handshake, rdata=0xDEADBEEF, rresp=00.
- W presented 3 cycles before AW, strb 0101 -> no memory access until both captured; byteenable=0101 in WR_EXEC.
- AW and AR asserted simultaneously from reset -> write served first, then read; repeat both -> order alternates W,R,W,R.
- Read addr 0x200 (word 128) -> no chipselect, rresp=10, rdata=0; write 0x3FC -> bresp=10, no write strobe.
- Reset asserted during RD_WAIT with rready=0 -> next cycle rvalid=0, arready=0, chipselect=0, state IDLE, mem_reset_req=1 while reset high.
